// File: rtl/exec_trace_if.sv
// Bus bundle between the MIPS core/debug mux and exec_trace_buf.
// The master drives fetch/trace/read-select signals and the slave returns read data and status.
interface exec_trace_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  clr;
    logic                  fetch;
    logic [31:0]           pc;
    logic [31:0]           instr;
    logic                  brk_en;
    logic [31:0]           brk_pc;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [1:0]            rd_sel;
    logic [31:0]           rd_data;
    logic [DEPTH_LOG2:0]   depth;
    logic                  frozen;

    modport master (
        output clr, fetch, pc, instr, brk_en, brk_pc, rd_idx, rd_sel,
        input  rd_data, depth, frozen
    );
    modport slave (
        input  clr, fetch, pc, instr, brk_en, brk_pc, rd_idx, rd_sel,
        output rd_data, depth, frozen
    );
endinterface

// File: rtl/exec_trace_buf.sv
// Circular fetch trace (last 2**DEPTH_LOG2 fetches) plus cycle/instruction-class counters.
// Define EXEC_TRACE_BRK_EN to enable the PC breakpoint that freezes capture.
module exec_trace_buf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CLS_W      = 8
) (
    input  logic         clk_cpu,
    input  logic         rst_cpu,
    exec_trace_if.slave  bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_ent_t;

    localparam int                     N        = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0]  WP_ONE   = DEPTH_LOG2'(1);
    localparam logic [CLS_W-1:0]       CLS_MAX  = '1;
    localparam logic [CLS_W-1:0]       CLS_ONE  = CLS_W'(1);

    trace_ent_t            ent_mem [N];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2:0]   depth_q;
    logic [31:0]           cyc_cnt;
    logic [15:0]           ins_cnt;
    logic [CLS_W-1:0]      mem_cnt;
    logic [CLS_W-1:0]      bj_cnt;
    logic                  frozen_q;
    logic                  capture;
    logic                  is_mem;
    logic                  is_bj;
    logic [5:0]            opc;

    always_comb begin
        opc     = bus.instr[31:26];
        capture = bus.fetch & ~frozen_q & ~bus.clr;
        is_mem  = (opc == 6'b100011) || (opc == 6'b101011);
        is_bj   = (opc == 6'b000100) || (opc == 6'b000010);
    end

    // Storage is never cleared; depth_q masks stale entries on read.
    always_ff @(posedge clk_cpu) begin
        if (capture) ent_mem[wp] <= '{pc: bus.pc, instr: bus.instr};
    end

    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu) begin
            wp      <= '0;
            depth_q <= '0;
            cyc_cnt <= '0;
            ins_cnt <= '0;
            mem_cnt <= '0;
            bj_cnt  <= '0;
        end else if (bus.clr) begin
            wp      <= '0;
            depth_q <= '0;
            cyc_cnt <= '0;
            ins_cnt <= '0;
            mem_cnt <= '0;
            bj_cnt  <= '0;
        end else if (!frozen_q) begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (capture) begin
                wp      <= wp + WP_ONE;
                ins_cnt <= ins_cnt + 16'd1;
                if (depth_q != FULL)          depth_q <= depth_q + (DEPTH_LOG2+1)'(1);
                if (is_mem && mem_cnt != CLS_MAX) mem_cnt <= mem_cnt + CLS_ONE;
                if (is_bj  && bj_cnt  != CLS_MAX) bj_cnt  <= bj_cnt  + CLS_ONE;
            end
        end
    end

`ifdef EXEC_TRACE_BRK_EN
    logic brk_hit;
    always_comb brk_hit = capture & bus.brk_en & (bus.pc == bus.brk_pc);

    // The matching fetch is still recorded; freezing takes effect after that edge.
    always_ff @(posedge clk_cpu or posedge rst_cpu) begin
        if (rst_cpu)      frozen_q <= 1'b0;
        else if (bus.clr) frozen_q <= 1'b0;
        else if (brk_hit) frozen_q <= 1'b1;
    end
`else
    logic unused_brk;
    assign unused_brk = bus.brk_en ^ (^bus.brk_pc);
    assign frozen_q   = 1'b0;
`endif

    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  ent_vld;
    trace_ent_t            rd_ent;
    logic [15+2*CLS_W:0]   cls_pack;

    always_comb begin
        rd_addr  = wp - WP_ONE - bus.rd_idx;
        ent_vld  = {1'b0, bus.rd_idx} < depth_q;
        rd_ent   = ent_mem[rd_addr];
        cls_pack = {ins_cnt, mem_cnt, bj_cnt};
        bus.rd_data = '0;
        case (bus.rd_sel)
            2'b00:   bus.rd_data = ent_vld ? rd_ent.pc    : 32'd0;
            2'b01:   bus.rd_data = ent_vld ? rd_ent.instr : 32'd0;
            2'b10:   bus.rd_data = cyc_cnt;
            default: bus.rd_data = 32'(cls_pack);
        endcase
    end

    assign bus.depth  = depth_q;
    assign bus.frozen = frozen_q;
endmodule
